// File: rtl/boolean_propose_seq_pkg.sv
// Shared constants and encodings for the Boolean proposal unit.
package boolean_propose_seq_pkg;

  localparam int          NUMBER_OF_BOOLEAN_VARIABLES = 16;
  // Galois taps for x^16+x^14+x^13+x^11+1 with a right-shifting register
  localparam logic [15:0] LFSR_POLY_16      = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLIP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_DIRECTED = 1'b0,
    MODE_RANDOM   = 1'b1
  } mode_e;

endpackage

// File: rtl/boolean_propose_seq_if.sv
// Request/result bundle between the sampler controller and the proposal unit.
interface boolean_propose_seq_if #(
  parameter int NUM_VARS    = 16,
  parameter int INDEX_WIDTH = $clog2(NUM_VARS),
  parameter int FLIP_WIDTH  = 4,
  parameter int LFSR_WIDTH  = 16
);
  logic                   in_start;
  logic                   in_mode;
  logic [0:NUM_VARS-1]    in_current_assignment_boolean;
  logic [INDEX_WIDTH-1:0] in_variable_to_be_changed_index;
  logic [FLIP_WIDTH-1:0]  in_num_flips;
  logic                   in_seed_load;
  logic [LFSR_WIDTH-1:0]  in_seed;
  logic                   out_ready;
  logic                   out_valid;
  logic [0:NUM_VARS-1]    out_new_assignment_boolean;
  logic [0:NUM_VARS-1]    out_flip_mask;
  logic                   out_error;

  modport master (
    output in_start, in_mode, in_current_assignment_boolean,
           in_variable_to_be_changed_index, in_num_flips, in_seed_load, in_seed,
    input  out_ready, out_valid, out_new_assignment_boolean, out_flip_mask, out_error
  );

  modport slave (
    input  in_start, in_mode, in_current_assignment_boolean,
           in_variable_to_be_changed_index, in_num_flips, in_seed_load, in_seed,
    output out_ready, out_valid, out_new_assignment_boolean, out_flip_mask, out_error
  );
endinterface

// File: rtl/boolean_propose_seq_lfsr_galois.sv
// Galois LFSR: right shift, taps XORed in when the bit shifted out is 1.
// Latency: state moves one step per cycle with advance; load takes effect next cycle.
// Backpressure: none; a zero seed is replaced by SEED so the register never locks up.
module boolean_propose_seq_lfsr_galois #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = boolean_propose_seq_pkg::LFSR_POLY_16,
  parameter logic [WIDTH-1:0] SEED  = boolean_propose_seq_pkg::LFSR_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= SEED;
    end else if (load) begin
      state <= (seed == '0) ? SEED : seed;
    end else if (advance) begin
      state <= {1'b0, state[WIDTH-1:1]} ^ (state[0] ? POLY : '0);
    end
  end

endmodule

// File: rtl/boolean_propose_seq.sv
// Proposes a neighbouring Boolean assignment: one chosen flip or K distinct LFSR-chosen flips.
// Latency: accept at N -> out_valid at N+1+max(1, K+rejections); directed is always N+2.
// Backpressure: out_ready only in IDLE; starts during FLIP/DONE are dropped, result held until next DONE.
module boolean_propose_seq
  import boolean_propose_seq_pkg::*;
#(
  parameter int                    NUM_VARS    = NUMBER_OF_BOOLEAN_VARIABLES,
  parameter int                    INDEX_WIDTH = $clog2(NUM_VARS),
  parameter int                    FLIP_WIDTH  = 4,
  parameter int                    LFSR_WIDTH  = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = LFSR_WIDTH'(LFSR_DEFAULT_SEED),
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = LFSR_WIDTH'(LFSR_POLY_16)
) (
  input logic                  in_clk,
  input logic                  in_reset_n,
  boolean_propose_seq_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_VARS + 1);

  state_e                 state_q, state_d;
  mode_e                  mode_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [0:NUM_VARS-1]    work_q, work_d, mask_q, mask_d;
  logic [0:NUM_VARS-1]    new_q, fmask_q;
  logic                   err_q, err_d;
  logic [0:NUM_VARS-1]    dir_hot, cand_hot;
  logic [LFSR_WIDTH-1:0]  lfsr_state;
  logic [INDEX_WIDTH-1:0] cand;
  logic                   start_acc, accept, lfsr_unused;

  assign start_acc   = (state_q == ST_IDLE) && bus.in_start;
  assign cand        = lfsr_state[INDEX_WIDTH-1:0];
  assign lfsr_unused = ^lfsr_state;

  boolean_propose_seq_lfsr_galois #(
    .WIDTH (LFSR_WIDTH),
    .POLY  (LFSR_POLY),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk     (in_clk),
    .reset_n (in_reset_n),
    .advance (state_q == ST_FLIP && mode_q == MODE_RANDOM),
    .load    (state_q == ST_IDLE && bus.in_seed_load && !bus.in_start),
    .seed    (bus.in_seed),
    .state   (lfsr_state)
  );

  // One-hot decodes; an out-of-range index decodes to all zeros
  always_comb begin
    dir_hot  = '0;
    cand_hot = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      dir_hot[i]  = (idx_q == INDEX_WIDTH'(i));
      cand_hot[i] = (cand == INDEX_WIDTH'(i));
    end
  end

  assign accept = |(cand_hot & ~mask_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mask_d  = mask_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_start) begin
          state_d = ST_FLIP;
          work_d  = bus.in_current_assignment_boolean;
          mask_d  = '0;
          err_d   = 1'b0;
          if (bus.in_mode == MODE_DIRECTED) begin
            cnt_d = CNT_W'(1);
          end else if (int'(bus.in_num_flips) > NUM_VARS) begin
            cnt_d = CNT_W'(NUM_VARS);
          end else begin
            cnt_d = CNT_W'(bus.in_num_flips);
          end
        end
      end
      ST_FLIP: begin
        if (mode_q == MODE_DIRECTED) begin
          work_d  = work_q ^ dir_hot;
          mask_d  = mask_q | dir_hot;
          err_d   = ~|dir_hot;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else if (accept) begin
          work_d = work_q ^ cand_hot;
          mask_d = mask_q | cand_hot;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_DIRECTED;
      idx_q   <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      new_q   <= '0;
      fmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      if (start_acc) begin
        mode_q <= mode_e'(bus.in_mode);
        idx_q  <= bus.in_variable_to_be_changed_index;
      end
      // Results publish on entry to DONE, including the final flip made this cycle
      if (state_q == ST_FLIP && state_d == ST_DONE) begin
        new_q   <= work_d;
        fmask_q <= mask_d;
      end
    end
  end

  assign bus.out_ready                  = (state_q == ST_IDLE);
  assign bus.out_valid                  = (state_q == ST_DONE);
  assign bus.out_new_assignment_boolean = new_q;
  assign bus.out_flip_mask              = fmask_q;
  assign bus.out_error                  = err_q;

endmodule

// File: tb/tb_boolean_propose_seq.sv
// Scoreboard bench: three instances (2, 16 with 5-bit index, 4 variables) driven by directed vectors.
module tb_boolean_propose_seq;

  typedef struct {
    int          dut;
    logic [15:0] asg;
    logic [15:0] mask;
    logic        err;
    int          lat;
    int          acc;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  int          vcount[3];
  int          reqs[3];

  logic        rst_n[3];
  logic        start_s[3], mode_s[3], seedld_s[3];
  logic [15:0] asg_s[3], seed_s[3];
  logic [4:0]  idx_s[3];
  logic [3:0]  k_s[3];
  logic        vld[3], rdy[3], err[3];
  logic [15:0] nasg[3], fmask[3];

  boolean_propose_seq_if #(.NUM_VARS(2),  .INDEX_WIDTH(1)) if_a ();
  boolean_propose_seq_if #(.NUM_VARS(16), .INDEX_WIDTH(5)) if_b ();
  boolean_propose_seq_if #(.NUM_VARS(4),  .INDEX_WIDTH(2)) if_c ();

  boolean_propose_seq #(.NUM_VARS(2),  .INDEX_WIDTH(1)) dut_a (.in_clk(clk), .in_reset_n(rst_n[0]), .bus(if_a));
  boolean_propose_seq #(.NUM_VARS(16), .INDEX_WIDTH(5)) dut_b (.in_clk(clk), .in_reset_n(rst_n[1]), .bus(if_b));
  boolean_propose_seq #(.NUM_VARS(4),  .INDEX_WIDTH(2)) dut_c (.in_clk(clk), .in_reset_n(rst_n[2]), .bus(if_c));

  assign if_a.in_start = start_s[0];
  assign if_a.in_mode = mode_s[0];
  assign if_a.in_current_assignment_boolean = asg_s[0][1:0];
  assign if_a.in_variable_to_be_changed_index = idx_s[0][0:0];
  assign if_a.in_num_flips = k_s[0];
  assign if_a.in_seed_load = seedld_s[0];
  assign if_a.in_seed = seed_s[0];
  assign vld[0] = if_a.out_valid;
  assign rdy[0] = if_a.out_ready;
  assign err[0] = if_a.out_error;
  assign nasg[0] = {14'b0, if_a.out_new_assignment_boolean};
  assign fmask[0] = {14'b0, if_a.out_flip_mask};

  assign if_b.in_start = start_s[1];
  assign if_b.in_mode = mode_s[1];
  assign if_b.in_current_assignment_boolean = asg_s[1];
  assign if_b.in_variable_to_be_changed_index = idx_s[1];
  assign if_b.in_num_flips = k_s[1];
  assign if_b.in_seed_load = seedld_s[1];
  assign if_b.in_seed = seed_s[1];
  assign vld[1] = if_b.out_valid;
  assign rdy[1] = if_b.out_ready;
  assign err[1] = if_b.out_error;
  assign nasg[1] = if_b.out_new_assignment_boolean;
  assign fmask[1] = if_b.out_flip_mask;

  assign if_c.in_start = start_s[2];
  assign if_c.in_mode = mode_s[2];
  assign if_c.in_current_assignment_boolean = asg_s[2][3:0];
  assign if_c.in_variable_to_be_changed_index = idx_s[2][1:0];
  assign if_c.in_num_flips = k_s[2];
  assign if_c.in_seed_load = seedld_s[2];
  assign if_c.in_seed = seed_s[2];
  assign vld[2] = if_c.out_valid;
  assign rdy[2] = if_c.out_ready;
  assign err[2] = if_c.out_error;
  assign nasg[2] = {12'b0, if_c.out_new_assignment_boolean};
  assign fmask[2] = {12'b0, if_c.out_flip_mask};

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid strobe must match the oldest outstanding expectation
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (vld[d] === 1'b1) begin
        exp_t e;
        vcount[d]++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: dut %0d strobed out_valid with nothing outstanding (cycle %0d)", d, cyc);
        end else begin
          e = sb.pop_front();
          check("dut_id", d, e.dut);
          check("assignment", nasg[d], e.asg);
          check("flip_mask", fmask[d], e.mask);
          check("error", err[d], e.err);
          check("latency", cyc - e.acc, e.lat);
          check("popcount", $countones(fmask[d]), e.k);
        end
      end
    end
  end

  // Called #1 after a rising edge with the target unit idle; returns #1 after the accepting edge
  task automatic start_req(input int d, input logic mode, input logic [15:0] a, input logic [4:0] idx,
                           input logic [3:0] k, input logic sl, input logic [15:0] seed,
                           input logic [15:0] em, input logic ee, input int lat, input int kexp);
    exp_t e;
    check("ready_idle", rdy[d], 1);
    start_s[d] = 1'b1;
    mode_s[d] = mode;
    asg_s[d] = a;
    idx_s[d] = idx;
    k_s[d] = k;
    seedld_s[d] = sl;
    seed_s[d] = seed;
    e.dut = d;
    e.asg = a ^ em;
    e.mask = em;
    e.err = ee;
    e.lat = lat;
    e.acc = cyc;
    e.k = kexp;
    sb.push_back(e);
    reqs[d]++;
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
    seedld_s[d] = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("outstanding_after_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic load_seed(input int d, input logic [15:0] v);
    seedld_s[d] = 1'b1;
    seed_s[d] = v;
    @(posedge clk);
    #1;
    seedld_s[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      start_s[d] = 1'b0;
      mode_s[d] = 1'b0;
      seedld_s[d] = 1'b0;
      asg_s[d] = '0;
      seed_s[d] = '0;
      idx_s[d] = '0;
      k_s[d] = '0;
      vcount[d] = 0;
      reqs[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check("reset_ready", rdy[d], 1);
      check("reset_valid", vld[d], 0);
      check("reset_assignment", nasg[d], 0);
      check("reset_mask", fmask[d], 0);
      check("reset_error", err[d], 0);
    end

    // Two variables, directed flips (bit 0 of the vector is the leftmost)
    start_req(0, 1'b0, 16'h0000, 5'd0, 4'd0, 1'b0, 16'h0, 16'h0002, 1'b0, 2, 1); wait_empty();
    start_req(0, 1'b0, 16'h0001, 5'd1, 4'd0, 1'b0, 16'h0, 16'h0001, 1'b0, 2, 1); wait_empty();
    start_req(0, 1'b0, 16'h0001, 5'd0, 4'd0, 1'b0, 16'h0, 16'h0002, 1'b0, 2, 1); wait_empty();

    // A start raised while FLIP is in progress must be dropped
    start_req(0, 1'b0, 16'h0000, 5'd1, 4'd0, 1'b0, 16'h0, 16'h0001, 1'b0, 2, 1);
    check("ready_flip_a", rdy[0], 0);
    start_s[0] = 1'b1;
    idx_s[0] = 5'd0;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    wait_empty();
    repeat (4) @(posedge clk);
    #1;
    check("valid_count_a", vcount[0], reqs[0]);

    // Sixteen variables with a 5-bit index: last variable, then out of range
    start_req(1, 1'b0, 16'h1234, 5'd15, 4'd0, 1'b0, 16'h0, 16'h0001, 1'b0, 2, 1); wait_empty();
    start_req(1, 1'b0, 16'h1234, 5'd16, 4'd0, 1'b0, 16'h0, 16'h0000, 1'b1, 2, 0); wait_empty();
    start_req(1, 1'b0, 16'h0000, 5'd0,  4'd0, 1'b0, 16'h0, 16'h8000, 1'b0, 2, 1); wait_empty();

    // Seed 1, K=3: accepts 1, 0, then six rejects, then 8 -> 9 FLIP cycles
    load_seed(1, 16'h0001);
    start_req(1, 1'b1, 16'h0000, 5'd0, 4'd3, 1'b0, 16'h0, 16'hC080, 1'b0, 10, 3); wait_empty();
    load_seed(1, 16'h0001);
    start_req(1, 1'b1, 16'hBEEF, 5'd0, 4'd0, 1'b0, 16'h0, 16'h0000, 1'b0, 2, 0); wait_empty();
    // Seed load alongside start is dropped, so the seed-1 sequence repeats
    load_seed(1, 16'h0001);
    start_req(1, 1'b1, 16'hFFFF, 5'd0, 4'd3, 1'b1, 16'h1234, 16'hC080, 1'b0, 10, 3); wait_empty();

    // Four variables: zero seed becomes ACE1; K=15 clamps to 4 (accepts 1,0,2,3 over 6 cycles)
    load_seed(2, 16'h0000);
    start_req(2, 1'b1, 16'h0005, 5'd0, 4'd15, 1'b0, 16'h0, 16'h000F, 1'b0, 7, 4); wait_empty();
    load_seed(2, 16'hACE1);
    start_req(2, 1'b1, 16'h0000, 5'd0, 4'd2, 1'b0, 16'h0, 16'h000C, 1'b0, 3, 2); wait_empty();
    start_req(2, 1'b0, 16'h0000, 5'd3, 4'd0, 1'b0, 16'h0, 16'h0001, 1'b0, 2, 1); wait_empty();

    // Reset in the middle of a long random FLIP aborts it with no strobe
    load_seed(1, 16'h0001);
    start_s[1] = 1'b1;
    mode_s[1] = 1'b1;
    k_s[1] = 4'd3;
    asg_s[1] = 16'hFFFF;
    @(posedge clk);
    #1;
    start_s[1] = 1'b0;
    check("ready_flip_b", rdy[1], 0);
    start_s[1] = 1'b1;
    mode_s[1] = 1'b0;
    @(posedge clk);
    #1;
    start_s[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    check("abort_ready", rdy[1], 1);
    check("abort_valid", vld[1], 0);
    check("abort_assignment", nasg[1], 0);
    check("abort_mask", fmask[1], 0);
    check("abort_error", err[1], 0);
    repeat (15) @(posedge clk);
    #1;
    check("valid_count_b", vcount[1], reqs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boolean_propose_seq.md
Name: boolean_propose_seq

Overview:
Sequential, parametrised Boolean proposal unit for the MCMC solver's proposal stage. It takes the current Boolean assignment and returns a neighbouring assignment.
- Directed mode flips one caller-chosen variable.
- Random mode flips K distinct variables chosen by an internal LFSR.
A start/ready/valid handshake connects it to the sampler controller, and its output feeds the acceptance (energy-compare) stage.

Parameters:
NUM_VARS, 16, number of Boolean variables; must be at least 2.
INDEX_WIDTH, $clog2(NUM_VARS), width of a variable index.
FLIP_WIDTH, 4, width of the requested flip count.
LFSR_WIDTH, 16, LFSR state width; must be at least INDEX_WIDTH.
LFSR_SEED, 16'hACE1, reset seed and substitute for a zero seed.

Ports:
in_clk  input  1  clock
in_reset_n  input  1  reset
in_start  input  1  request; accepted only when out_ready=1
in_mode  input  1  0=directed, 1=random
in_current_assignment_boolean  input  [0:NUM_VARS-1]  assignment to perturb; bit i is variable i
in_variable_to_be_changed_index  input  INDEX_WIDTH  directed-mode index
in_num_flips  input  FLIP_WIDTH  random-mode flip count K
in_seed_load  input  1  load in_seed into the LFSR
in_seed  input  LFSR_WIDTH  new seed
out_ready  output  1  high in IDLE
out_valid  output  1  one-cycle result strobe
out_new_assignment_boolean  output  [0:NUM_VARS-1]  proposed assignment
out_flip_mask  output  [0:NUM_VARS-1]  1 marks each flipped variable
out_error  output  1  directed index out of range; qualified by out_valid

Behaviour:
Reset and clocking:
- Single clock in_clk. Reset is synchronous and active-low via in_reset_n, sampled on the rising edge of in_clk.
- Reset values: state=IDLE, out_valid=0, out_error=0, out_new_assignment_boolean=0, out_flip_mask=0, LFSR=LFSR_SEED.
- out_ready=1 once the IDLE state is registered.
- Reset mid-operation aborts the request. No out_valid is produced, and the result registers clear.

FSM states: IDLE, FLIP, DONE.

IDLE:
- out_ready=1.
- On in_start: latch the assignment into a work register, clear the mask, clear the error, and go to FLIP.
- Flip counter on acceptance:
  - directed mode: counter=1;
  - random mode: counter=min(in_num_flips, NUM_VARS).
- in_seed_load is honoured only in IDLE and only without in_start. A zero seed loads LFSR_SEED. Seed loads in any other state are ignored.
- If in_start and in_seed_load are both high, in_start wins and the seed is dropped.

FLIP (out_ready=0):
- Directed mode:
  - index < NUM_VARS: invert that bit and set its mask bit.
  - index >= NUM_VARS: no change, out_error=1.
  - Then go to DONE.
- Random mode:
  - Counter 0 on entry: go to DONE.
  - Otherwise the candidate is the LFSR's low INDEX_WIDTH bits.
  - The candidate is accepted if it is < NUM_VARS and its mask bit is 0. Accepting inverts the bit, sets the mask bit and decrements the counter.
  - A rejected candidate costs one cycle with no change.
  - Go to DONE when the counter reaches 0.
- The LFSR advances once per FLIP cycle in random mode only, so results are deterministic for a given seed.

DONE:
- out_valid=1 for exactly one cycle.
- out_new_assignment_boolean and out_flip_mask update on this cycle and hold until the next DONE.
- Next state is IDLE. in_start during FLIP or DONE is ignored.

Latency: request accepted at cycle N gives out_valid at cycle N+1+max(1, K+R), where R is the number of rejections.
- Directed mode and K=0: out_valid at N+2.
- Throughput: one request per 3 cycles at best.

LFSR: Galois form, polynomial x^16+x^14+x^13+x^11+1 for LFSR_WIDTH=16. It can never hold zero.

Invariants: popcount(out_flip_mask)=K after clamping. out_new_assignment_boolean equals the latched input XOR out_flip_mask.

Decomposition:
- headers.v holds:
  - NUMBER_OF_BOOLEAN_VARIABLES, the default for NUM_VARS;
  - the LFSR polynomial and default seed;
  - the FSM state encodings (2-bit) and the mode encodings.
- One sub-module, lfsr_galois, parametrised by width and polynomial, with ports: clock, reset, advance, load, seed, state.
- Flip/mask logic and the FSM stay in boolean_propose_seq.

Test Plan:
1. Reset, then directed mode with NUM_VARS=2, input 2'b00, index 0 -> out_valid at N+2; assignment 2'b10; mask 2'b10; out_error=0.
2. Directed mode, input 2'b01, index 1 -> assignment 2'b00, mask 2'b01. Repeat with index 0 -> assignment 2'b11.
3. NUM_VARS=16, directed mode, index 15 then index 16 (with INDEX_WIDTH widened to 5) -> first flips bit 15 only. Second gives assignment equal to input, mask 0, out_error=1.
4. Random mode, seed 16'h0001, K=3, input 16'h0000 -> popcount(mask)=3, assignment=mask, indices distinct and matching the golden-model LFSR sequence. Also K=0 -> assignment equals input, valid at N+2.
5. Random mode, K=15 with NUM_VARS=4 -> clamped to 4, assignment = ~input. Seed load of 0 -> LFSR=16'hACE1.
6. Assert in_start during FLIP, then in_reset_n=0 mid-FLIP -> second start ignored; after reset no out_valid, outputs are 0, and out_ready=1.
